// File: rtl/qu_common.sv
// Shared types for the data-memory port.
//   sb_entry_t        : one posted store {word address, data}
//   dmem_port_state_t : load-sequencing FSM states of dmem_port
package qu_common;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] data;
   } sb_entry_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_DRAIN,
      RD_REQ,
      RD_WAIT,
      RESP
   } dmem_port_state_t;

endpackage

// File: rtl/dmem_port_store_buffer.sv
// store_buffer: in-order posted-store FIFO with a youngest-match lookup.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_entry: enqueue a store (accepted when not full, or full with a pop)
//   pop             : dequeue the head entry (ignored when empty)
//   head            : oldest entry
//   count           : occupancy, 0..DEPTH
//   full, empty     : occupancy flags
//   dropped         : a push was refused this cycle (full, no pop)
//   lookup_waddr    : word address to search for
//   hit, hit_data   : youngest valid entry with matching address, and its data
module store_buffer
   import qu_common::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  sb_entry_t                push_entry,
   input  logic                     pop,
   output sb_entry_t                head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     dropped,
   input  logic [29:0]              lookup_waddr,
   output logic                     hit,
   output logic [31:0]              hit_data
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   sb_entry_t         mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dropped = push && full && !do_pop;
   assign head    = mem[rd_ptr];

   // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PW + 1)'(i) < count) &&
             (mem[rd_ptr + PW'(i)].waddr == lookup_waddr)) begin
            hit      = 1'b1;
            hit_data = mem[rd_ptr + PW'(i)].data;
         end
      end
   end

endmodule

// File: rtl/dmem_port.sv
// dmem_port: retire-side data-memory port.
//   Stores are posted into a store buffer and drained to the bus in order.
//   Loads forward from the buffer when possible, otherwise wait for the
//   buffer to drain and issue a bus read. Each load completes with a
//   one-cycle dmem_valid pulse carrying dmem_rdata.
//   clk, rst                        : clock, synchronous active-high reset
//   dmem_wr_en/rd_en/addr/wdata     : retire request side
//   dmem_valid, dmem_rdata          : load completion (registered)
//   mem_req/we/addr/wdata, mem_gnt  : bus request, held until granted
//   mem_rvalid, mem_rdata           : bus read return
//   sb_count, sb_overflow           : buffer occupancy, sticky drop flag
module dmem_port
   import qu_common::*;
#(
   parameter int SB_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dmem_wr_en,
   input  logic                        dmem_rd_en,
   input  logic [31:0]                 dmem_addr,
   input  logic [31:0]                 dmem_wdata,
   output logic                        dmem_valid,
   output logic [31:0]                 dmem_rdata,
   output logic                        mem_req,
   output logic                        mem_we,
   output logic [31:0]                 mem_addr,
   output logic [31:0]                 mem_wdata,
   input  logic                        mem_gnt,
   input  logic                        mem_rvalid,
   input  logic [31:0]                 mem_rdata,
   output logic [$clog2(SB_DEPTH):0]   sb_count,
   output logic                        sb_overflow
);

   dmem_port_state_t state;
   dmem_port_state_t next_state;

   sb_entry_t   push_entry;
   sb_entry_t   sb_head;
   logic        sb_full;
   logic        sb_empty;
   logic        sb_dropped;
   logic        sb_hit;
   logic [31:0] sb_hit_data;
   logic        sb_pop;
   logic        drain_req;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [29:0] rd_waddr;
   logic [31:0] resp_data;

   assign push_entry = '{waddr: dmem_addr[31:2], data: dmem_wdata};

   store_buffer #(
      .DEPTH (SB_DEPTH)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .push         (dmem_wr_en),
      .push_entry   (push_entry),
      .pop          (sb_pop),
      .head         (sb_head),
      .count        (sb_count),
      .full         (sb_full),
      .empty        (sb_empty),
      .dropped      (sb_dropped),
      .lookup_waddr (dmem_addr[31:2]),
      .hit          (sb_hit),
      .hit_data     (sb_hit_data)
   );

   // Loads and stores share dmem_addr, so a same-cycle store always matches
   // the load address and, being youngest, takes priority over the buffer.
   assign fwd_hit  = dmem_wr_en || sb_hit;
   assign fwd_data = dmem_wr_en ? dmem_wdata : sb_hit_data;

   // Drain is suppressed only while a read owns the bus. Reads are entered
   // only with an empty buffer, so a presented drain is never pre-empted.
   assign drain_req = !sb_empty && (state != RD_REQ) && (state != RD_WAIT);
   assign sb_pop    = drain_req && mem_gnt;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (dmem_rd_en) begin
               if (fwd_hit)                      next_state = RESP;
               else if (sb_empty && !dmem_wr_en) next_state = RD_REQ;
               else                              next_state = RD_DRAIN;
            end
         end
         // A push arriving this cycle keeps us waiting for it to drain too.
         RD_DRAIN: if (sb_empty && !dmem_wr_en) next_state = RD_REQ;
         RD_REQ:   if (mem_gnt)                 next_state = RD_WAIT;
         RD_WAIT:  if (mem_rvalid)              next_state = RESP;
         RESP:                                  next_state = IDLE;
         default:                               next_state = IDLE;
      endcase
   end

   // ---------------- bus outputs ----------------
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == RD_REQ) begin
         mem_req  = 1'b1;
         mem_addr = {rd_waddr, 2'b00};
      end else if (drain_req) begin
         mem_req   = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = {sb_head.waddr, 2'b00};
         mem_wdata = sb_head.data;
      end
   end

   // ---------------- load address and response registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_waddr <= '0;
      end else if (state == IDLE && dmem_rd_en) begin
         rd_waddr <= dmem_addr[31:2];
      end
   end

   // Response data is zero outside the RESP cycle so dmem_rdata is clean.
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         dmem_valid <= (next_state == RESP);
         if (next_state == RESP)
            resp_data <= (state == IDLE) ? fwd_data : mem_rdata;
         else
            resp_data <= '0;
      end
   end

   assign dmem_rdata = resp_data;

   always_ff @(posedge clk) begin
      if (rst)             sb_overflow <= 1'b0;
      else if (sb_dropped) sb_overflow <= 1'b1;
   end

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        dmem_wr_en, dmem_rd_en;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_valid;
   logic [31:0] dmem_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic [2:0]  sb_count;
   logic        sb_overflow;

   int n_chk  = 0;
   int n_pass = 0;

   // bus handshake log
   logic        q_we   [$];
   logic [31:0] q_addr [$];
   logic [31:0] q_data [$];
   int          rd_grants   = 0;
   int          seen_grants = 0;

   always #5 clk = ~clk;

   dmem_port #(.SB_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .dmem_wr_en  (dmem_wr_en),
      .dmem_rd_en  (dmem_rd_en),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_valid  (dmem_valid),
      .dmem_rdata  (dmem_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .sb_count    (sb_count),
      .sb_overflow (sb_overflow)
   );

   always @(posedge clk) begin
      if (!rst && mem_req && mem_gnt) begin
         q_we.push_back(mem_we);
         q_addr.push_back(mem_addr);
         q_data.push_back(mem_wdata);
         if (!mem_we) rd_grants++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      q_we.delete();
      q_addr.delete();
      q_data.delete();
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      dmem_wr_en = 1'b1;
      dmem_addr  = a;
      dmem_wdata = d;
      tick();
      dmem_wr_en = 1'b0;
   endtask

   // Holds dmem_rd_en high; returns edges until dmem_valid (-1 on timeout).
   // Bus read data is returned one cycle after each read grant.
   task automatic do_load(input logic [31:0] a, input logic [31:0] rv, input int maxc,
                          output int lat, output logic [31:0] data);
      dmem_rd_en = 1'b1;
      dmem_addr  = a;
      mem_rdata  = rv;
      lat  = -1;
      data = '0;
      for (int n = 1; n <= maxc; n++) begin
         tick();
         if (rd_grants != seen_grants) begin
            seen_grants = rd_grants;
            mem_rvalid  = 1'b1;
         end else begin
            mem_rvalid = 1'b0;
         end
         if (dmem_valid) begin
            lat  = n;
            data = dmem_rdata;
            break;
         end
      end
   endtask

   initial begin
      int          lat;
      int          pulses;
      logic [31:0] d;

      rst = 1'b1; dmem_wr_en = 0; dmem_rd_en = 0; dmem_addr = 0; dmem_wdata = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      check("rst_valid",    32'(dmem_valid),  0);
      check("rst_rdata",    dmem_rdata,       0);
      check("rst_req",      32'(mem_req),     0);
      check("rst_count",    32'(sb_count),    0);
      check("rst_overflow", 32'(sb_overflow), 0);

      // store forward, bus stalled
      store(32'h100, 32'hDEADBEEF);
      check("fwd_count",   32'(sb_count), 1);
      check("fwd_drn_req", 32'(mem_req),  1);
      check("fwd_drn_we",  32'(mem_we),   1);
      check("fwd_drn_adr", mem_addr,      32'h100);
      check("fwd_drn_dat", mem_wdata,     32'hDEADBEEF);
      do_load(32'h102, 32'h0, 10, lat, d);
      dmem_rd_en = 1'b0;
      check("fwd_lat",  32'(lat), 1);
      check("fwd_data", d,        32'hDEADBEEF);
      tick();
      check("fwd_pulse_end", 32'(dmem_valid), 0);
      check("fwd_no_read",   32'(rd_grants),  0);
      mem_gnt = 1'b1;
      tick(); tick();
      check("fwd_drained", 32'(sb_count), 0);

      // youngest entry wins
      mem_gnt = 1'b0;
      store(32'h40, 32'h1);
      store(32'h40, 32'h2);
      check("yng_count", 32'(sb_count), 2);
      do_load(32'h40, 32'h0, 10, lat, d);
      dmem_rd_en = 1'b0;
      check("yng_lat",  32'(lat), 1);
      check("yng_data", d,        32'h2);
      mem_gnt = 1'b1;
      tick(); tick(); tick();
      check("yng_drained", 32'(sb_count), 0);

      // read miss after drain: writes in order, then the read
      clear_log();
      store(32'h10, 32'hA);
      store(32'h14, 32'hB);
      do_load(32'h20, 32'h55, 20, lat, d);
      dmem_rd_en = 1'b0;
      check("miss_data",  d,                 32'h55);
      check("miss_nlog",  32'(q_we.size()),  3);
      if (q_we.size() >= 3) begin
         check("miss_w0_we",  32'(q_we[0]), 1);
         check("miss_w0_adr", q_addr[0],    32'h10);
         check("miss_w0_dat", q_data[0],    32'hA);
         check("miss_w1_adr", q_addr[1],    32'h14);
         check("miss_w1_dat", q_data[1],    32'hB);
         check("miss_r_we",   32'(q_we[2]), 0);
         check("miss_r_adr",  q_addr[2],    32'h20);
      end
      tick();

      // miss from empty buffer: T -> dmem_valid at T+3
      do_load(32'h24, 32'h66, 20, lat, d);
      dmem_rd_en = 1'b0;
      check("miss_lat",   32'(lat), 3);
      check("miss_data2", d,        32'h66);
      tick();

      // overflow: five stores into four entries with the bus stalled
      mem_gnt = 1'b0;
      clear_log();
      for (int i = 0; i < 5; i++) store(32'h200 + 32'(4 * i), 32'(i + 1));
      check("ovf_count", 32'(sb_count),    4);
      check("ovf_flag",  32'(sb_overflow), 1);
      tick(); tick();
      check("ovf_sticky", 32'(sb_overflow), 1);
      mem_gnt = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("ovf_drained",     32'(sb_count),       0);
      check("ovf_nlog",        32'(q_addr.size()),  4);
      if (q_addr.size() >= 4) begin
         check("ovf_last_adr", q_addr[3], 32'h20C);
         check("ovf_last_dat", q_data[3], 32'h4);
      end
      check("ovf_sticky2", 32'(sb_overflow), 1);

      // back-to-back loads with dmem_rd_en held high
      clear_log();
      do_load(32'h8, 32'h88, 20, lat, d);
      check("b2b_data0", d, 32'h88);
      do_load(32'hC, 32'hCC, 20, lat, d);
      dmem_rd_en = 1'b0;
      check("b2b_data1", d,        32'hCC);
      check("b2b_lat1",  32'(lat), 4);
      check("b2b_nlog",  32'(q_addr.size()), 2);
      if (q_addr.size() >= 2) begin
         check("b2b_adr0", q_addr[0], 32'h8);
         check("b2b_adr1", q_addr[1], 32'hC);
      end
      tick();

      // reset while waiting for read data
      dmem_rd_en = 1'b1;
      dmem_addr  = 32'h30;
      tick();
      check("rr_req", 32'(mem_req), 1);
      check("rr_we",  32'(mem_we),  0);
      tick();
      seen_grants = rd_grants;
      rst = 1'b1; dmem_rd_en = 1'b0; mem_gnt = 1'b0;
      tick();
      check("rr_valid",    32'(dmem_valid),  0);
      check("rr_rdata",    dmem_rdata,       0);
      check("rr_req0",     32'(mem_req),     0);
      check("rr_addr0",    mem_addr,         0);
      check("rr_count",    32'(sb_count),    0);
      check("rr_overflow", 32'(sb_overflow), 0);
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h77;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         mem_rvalid = 1'b0;
         if (dmem_valid) pulses++;
      end
      check("rr_no_valid", 32'(pulses), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
